arbitro_memoria_rtc: RTL

- Sequences and shares the RTC double-buffered register memory (`memoria_DMULC`) between two write requesters.
  - RTC: the bus read-back FSM that refreshes time/date registers.
  - USR: the keyboard/edit path that sets time, date or stopwatch.
- Drives the memory's whileT/w1/ADD1/DAT1 and uses its actready to know the shadow-to-output copy finished.
- Tells each requester when its burst has been committed.

---
 rtl/arbitro_memoria_rtc.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/arbitro_memoria_rtc.sv
// Arbiter sharing the RTC double-buffered register memory between the bus
// read-back requester (RTC) and the keyboard edit requester (USR).
module arbitro_memoria_rtc #(
  parameter logic [3:0]  ADD_IDLE  = 4'd15,
  parameter int unsigned SETUP_CYC = 2,
  parameter logic [5:0]  MAX_BURST = 6'd32,
  parameter logic [6:0]  TIMEOUT   = 7'd63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_rtc,
  input  logic       w_rtc,
  input  logic [3:0] add_rtc,
  input  logic [7:0] dat_rtc,
  input  logic       fin_rtc,
  input  logic       req_usr,
  input  logic       w_usr,
  input  logic [3:0] add_usr,
  input  logic [7:0] dat_usr,
  input  logic       fin_usr,
  input  logic       actready,
  output logic       whileT,
  output logic       w1,
  output logic [3:0] ADD1,
  output logic [7:0] DAT1,
  output logic       gnt_rtc,
  output logic       gnt_usr,
  output logic       done_rtc,
  output logic       done_usr,
  output logic       busy,
  output logic       err_to
);

  localparam int unsigned   CW         = 7;
  localparam logic          SRC_RTC    = 1'b0;
  localparam logic          SRC_USR    = 1'b1;
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 6'd1);

  typedef enum logic [2:0] {IDLE, ABRIR, CONCESION, CERRAR, FIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            win_q, win_d;
  logic            last_q;
  logic            actready_q;
  logic            act_rise;
  logic            fin_win, w_win;
  logic [3:0]      add_win;
  logic [7:0]      dat_win;

  logic            whileT_d, w1_d, gnt_rtc_d, gnt_usr_d;
  logic            done_rtc_d, done_usr_d, busy_d, err_d;
  logic [3:0]      add_d;
  logic [7:0]      dat_d;

  // actready stays high for several cycles; only its rising edge marks completion
  assign act_rise = actready & ~actready_q;

  assign fin_win = (win_q == SRC_USR) ? fin_usr : fin_rtc;
  assign w_win   = (win_q == SRC_USR) ? w_usr   : w_rtc;
  assign add_win = (win_q == SRC_USR) ? add_usr : add_rtc;
  assign dat_win = (win_q == SRC_USR) ? dat_usr : dat_rtc;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      win_q      <= SRC_RTC;
      last_q     <= SRC_USR;
      actready_q <= 1'b0;
      whileT     <= 1'b0;
      w1         <= 1'b0;
      ADD1       <= ADD_IDLE;
      DAT1       <= '0;
      gnt_rtc    <= 1'b0;
      gnt_usr    <= 1'b0;
      done_rtc   <= 1'b0;
      done_usr   <= 1'b0;
      busy       <= 1'b0;
      err_to     <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      actready_q <= actready;
      cnt_q      <= (state_d != state_q) ? '0 : cnt_q + CW'(1);
      if (state_q == FIN) last_q <= win_q;
      whileT     <= whileT_d;
      w1         <= w1_d;
      ADD1       <= add_d;
      DAT1       <= dat_d;
      gnt_rtc    <= gnt_rtc_d;
      gnt_usr    <= gnt_usr_d;
      done_rtc   <= done_rtc_d;
      done_usr   <= done_usr_d;
      busy       <= busy_d;
      err_to     <= err_d;
    end
  end

  // Next state; on a tie the requester that was not served last wins
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (req_rtc | req_usr) begin
          state_d = ABRIR;
          win_d   = (req_rtc & req_usr) ? ~last_q : req_usr;
        end
      end
      ABRIR:     if (cnt_q == SETUP_LAST) state_d = CONCESION;
      CONCESION: if (fin_win | (cnt_q == BURST_LAST)) state_d = CERRAR;
      CERRAR:    if (act_rise | (cnt_q == TIMEOUT)) state_d = FIN;
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    whileT_d   = 1'b0;
    w1_d       = 1'b0;
    add_d      = ADD_IDLE;
    dat_d      = '0;
    gnt_rtc_d  = 1'b0;
    gnt_usr_d  = 1'b0;
    done_rtc_d = 1'b0;
    done_usr_d = 1'b0;
    busy_d     = (state_d != IDLE);
    err_d      = err_to;
    if ((state_d == ABRIR) || (state_d == CONCESION)) whileT_d = 1'b1;
    if (state_d == CONCESION) begin
      gnt_rtc_d = (win_d == SRC_RTC);
      gnt_usr_d = (win_d == SRC_USR);
    end
    // Forwarding follows the registered grant, so the fin-cycle strobe still lands
    if (state_q == CONCESION) begin
      w1_d  = w_win;
      add_d = add_win;
      dat_d = dat_win;
    end
    if ((state_q == CERRAR) && (state_d == FIN)) begin
      done_rtc_d = (win_q == SRC_RTC);
      done_usr_d = (win_q == SRC_USR);
      err_d      = err_to | ~act_rise;
    end
  end

endmodule
